// File: rtl/ptp_udp_rx_parser.sv
// ptp_udp_rx_parser: filters PTP traffic from a UDP RX stream and emits one PTPv2 common-header descriptor per good message.
// Ports: clk/rst_n; s_udp_* header handshake (source IP, ports, length); s_udp_payload_axis_* byte stream (tuser = bad frame);
// ts_in free-running time; m_ptp_* descriptor handshake and fields; stat_drop_non_ptp / stat_drop_error one-cycle drop pulses.
module ptp_udp_rx_parser #(
  parameter int EVENT_PORT   = 319,
  parameter int GENERAL_PORT = 320,
  parameter int TS_WIDTH     = 80,
  parameter int PTP_VERSION  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_udp_hdr_valid,
  output logic                s_udp_hdr_ready,
  input  logic [31:0]         s_udp_ip_source_ip,
  input  logic [15:0]         s_udp_source_port,
  input  logic [15:0]         s_udp_dest_port,
  input  logic [15:0]         s_udp_length,
  input  logic [7:0]          s_udp_payload_axis_tdata,
  input  logic                s_udp_payload_axis_tvalid,
  output logic                s_udp_payload_axis_tready,
  input  logic                s_udp_payload_axis_tlast,
  input  logic                s_udp_payload_axis_tuser,
  input  logic [TS_WIDTH-1:0] ts_in,
  output logic                m_ptp_valid,
  input  logic                m_ptp_ready,
  output logic [3:0]          m_ptp_msg_type,
  output logic [15:0]         m_ptp_msg_length,
  output logic [7:0]          m_ptp_domain,
  output logic [15:0]         m_ptp_flags,
  output logic [63:0]         m_ptp_correction,
  output logic [79:0]         m_ptp_src_port_id,
  output logic [15:0]         m_ptp_seq_id,
  output logic                m_ptp_event,
  output logic [TS_WIDTH-1:0] m_ptp_ts,
  output logic [31:0]         m_ptp_src_ip,
  output logic                stat_drop_non_ptp,
  output logic                stat_drop_error
);
  typedef enum logic [2:0] {IDLE, HDR, DRAIN, DROP, OUT} state_t;
  state_t state, state_nx, eof_st;
  logic [5:0] cnt;
  // Header bytes are shifted in MSB-first; after 34 bytes byte i sits at hdr[271-8*i -: 8].
  logic [271:0] hdr;
  logic beat, last_beat, hdr_ok, ver_ok, nx_err, nx_np, unused;
  assign beat = s_udp_payload_axis_tvalid & s_udp_payload_axis_tready;
  assign last_beat = beat & s_udp_payload_axis_tlast;
  assign hdr_ok = (s_udp_dest_port == 16'(EVENT_PORT) || s_udp_dest_port == 16'(GENERAL_PORT)) && s_udp_length >= 16'd42;
  // On the byte-33 tlast beat only 33 bytes are shifted in yet, so byte1 is one position lower.
  assign ver_ok = (state == HDR ? hdr[251:248] : hdr[259:256]) == 4'(PTP_VERSION);
  assign eof_st = s_udp_payload_axis_tuser ? IDLE : ver_ok ? OUT : IDLE;
  assign s_udp_hdr_ready = state == IDLE;
  assign s_udp_payload_axis_tready = state == HDR || state == DRAIN || state == DROP;
  assign m_ptp_valid = state == OUT;
  assign m_ptp_msg_type = hdr[267:264];
  assign m_ptp_msg_length = hdr[255:240];
  assign m_ptp_domain = hdr[239:232];
  assign m_ptp_flags = hdr[223:208];
  assign m_ptp_correction = hdr[207:144];
  assign m_ptp_src_port_id = hdr[111:32];
  assign m_ptp_seq_id = hdr[31:16];
  assign unused = ^{s_udp_source_port, hdr[271:268], hdr[263:260], hdr[231:224], hdr[143:112], hdr[15:0]};
  always_comb begin
    state_nx = state;
    nx_err = 1'b0;
    nx_np = 1'b0;
    case (state)
      IDLE: if (s_udp_hdr_valid) state_nx = hdr_ok ? HDR : DROP;
      HDR: if (beat) begin
        if (cnt == 6'd33) begin
          state_nx = s_udp_payload_axis_tlast ? eof_st : DRAIN;
          nx_err = s_udp_payload_axis_tlast & s_udp_payload_axis_tuser;
          nx_np = s_udp_payload_axis_tlast & ~s_udp_payload_axis_tuser & ~ver_ok;
        end else if (s_udp_payload_axis_tlast) begin
          state_nx = IDLE;
          nx_err = 1'b1;
        end
      end
      DRAIN: if (last_beat) begin
        state_nx = eof_st;
        nx_err = s_udp_payload_axis_tuser;
        nx_np = ~s_udp_payload_axis_tuser & ~ver_ok;
      end
      DROP: if (last_beat) begin
        state_nx = IDLE;
        nx_np = 1'b1;
      end
      OUT: if (m_ptp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hdr <= '0;
      m_ptp_event <= 1'b0;
      m_ptp_ts <= '0;
      m_ptp_src_ip <= '0;
      stat_drop_non_ptp <= 1'b0;
      stat_drop_error <= 1'b0;
    end else begin
      state <= state_nx;
      stat_drop_non_ptp <= nx_np;
      stat_drop_error <= nx_err;
      if (state == IDLE && s_udp_hdr_valid) begin
        cnt <= '0;
        m_ptp_ts <= ts_in;
        m_ptp_src_ip <= s_udp_ip_source_ip;
        m_ptp_event <= s_udp_dest_port == 16'(EVENT_PORT);
      end
      if (state == HDR && beat) begin
        hdr <= {hdr[263:0], s_udp_payload_axis_tdata};
        cnt <= cnt + 6'd1;
      end
    end
  end
endmodule
